// File: rtl/htif_tohost_uart.sv
// htif_tohost_uart: polls the HTIF tohost CSR over the PCR request/response
// port. Each nonzero value is cleared and its low byte is sent as an 8N1 UART
// character.
// Build option: define TOHOST_HALT_EN to treat an odd tohost value as a
// program exit. The FSM then latches halted/exit_code and stops polling.

`ifndef CSR_ADDR_TO_HOST
`define CSR_ADDR_TO_HOST 12'h780
`endif

module htif_tohost_uart #(
    parameter int CLK_HZ   = 24000000,
    parameter int BAUD     = 115200,
    parameter int POLL_GAP = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        htif_pcr_req_valid,
    input  logic        htif_pcr_req_ready,
    output logic        htif_pcr_req_rw,
    output logic [11:0] htif_pcr_req_addr,
    output logic [63:0] htif_pcr_req_data,
    input  logic        htif_pcr_resp_valid,
    output logic        htif_pcr_resp_ready,
    input  logic [63:0] htif_pcr_resp_data,
    output logic        uart_txd,
    output logic        busy,
    output logic        halted,
    output logic [14:0] exit_code
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_GAP, S_RD_REQ, S_RD_RESP, S_WR_REQ, S_WR_RESP, S_TX, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [63:0]       tohost_q, tohost_d;
    logic              txd_q, txd_d;

    logic gap_done;
    logic tx_done;
    logic halt_req;
    logic [2:0] data_idx;

    assign gap_done = (gap_cnt_q == GAP_LAST);
    // Bit 9 is the stop bit; the character is done on its last baud tick.
    assign tx_done  = (bit_cnt_q == 4'd9) && (baud_cnt_q == BAUD_LAST);
    assign data_idx = 3'(bit_cnt_q - 4'd1);

`ifdef TOHOST_HALT_EN
    assign halt_req  = tohost_q[0];
    assign halted    = (state_q == S_HALT);
    assign exit_code = halted ? tohost_q[15:1] : 15'd0;
`else
    assign halt_req  = 1'b0;
    assign halted    = 1'b0;
    assign exit_code = 15'd0;
`endif

    // Only tohost is ever accessed, and the only write is the clear.
    assign htif_pcr_req_addr = `CSR_ADDR_TO_HOST;
    assign htif_pcr_req_data = 64'h0;
    assign uart_txd          = txd_q;

    // State register; reset abandons any handshake or character and restarts the gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_GAP;
        else       state_q <= state_d;
    end

    // Next-state logic: poll, clear if nonzero, then print or halt.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_GAP:     if (gap_done) state_d = S_RD_REQ;
            S_RD_REQ:  if (htif_pcr_req_ready) state_d = S_RD_RESP;
            S_RD_RESP: if (htif_pcr_resp_valid)
                           state_d = (htif_pcr_resp_data == 64'h0) ? S_GAP : S_WR_REQ;
            S_WR_REQ:  if (htif_pcr_req_ready) state_d = S_WR_RESP;
            S_WR_RESP: if (htif_pcr_resp_valid) state_d = halt_req ? S_HALT : S_TX;
            S_TX:      if (tx_done) state_d = S_GAP;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_GAP;
        endcase
    end

    // Handshake outputs decoded from the current state only, so they hold steady until accepted.
    always_comb begin
        htif_pcr_req_valid  = 1'b0;
        htif_pcr_req_rw     = 1'b0;
        htif_pcr_resp_ready = 1'b0;
        busy                = 1'b1;
        case (state_q)
            S_GAP:     busy = 1'b0;
            S_RD_REQ:  htif_pcr_req_valid = 1'b1;
            S_RD_RESP: htif_pcr_resp_ready = 1'b1;
            S_WR_REQ: begin
                htif_pcr_req_valid = 1'b1;
                htif_pcr_req_rw    = 1'b1;
            end
            S_WR_RESP: htif_pcr_resp_ready = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next state: gap timer, read capture, baud/bit counters and the serial bit.
    always_comb begin
        gap_cnt_d  = '0;
        baud_cnt_d = '0;
        bit_cnt_d  = 4'd0;
        tohost_d   = tohost_q;
        txd_d      = 1'b1;

        if (state_q == S_GAP && !gap_done)
            gap_cnt_d = gap_cnt_q + 1'b1;

        // A response outside RD_RESP never touches the capture register.
        if (state_q == S_RD_RESP && htif_pcr_resp_valid)
            tohost_d = htif_pcr_resp_data;

        // Counters sit at zero outside TX, so each TX entry starts a fresh frame.
        // txd is registered, so the start bit appears the cycle after entry.
        if (state_q == S_TX && !tx_done) begin
            if (baud_cnt_q == BAUD_LAST) begin
                baud_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                baud_cnt_d = baud_cnt_q + 1'b1;
                bit_cnt_d  = bit_cnt_q;
            end
            if (bit_cnt_q == 4'd0)      txd_d = 1'b0;
            else if (bit_cnt_q <= 4'd8) txd_d = tohost_q[data_idx];
            else                        txd_d = 1'b1;
        end
    end

    // Datapath registers; the line idles high and the capture clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt_q  <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            tohost_q   <= 64'h0;
            txd_q      <= 1'b1;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            gap_cnt_q  <= gap_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tohost_q   <= tohost_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: tb/tb_htif_tohost_uart.sv
// Directed bench for htif_tohost_uart. A small HTIF host model answers PCR
// requests from a tohost variable, and a UART sampler decodes frames at mid-bit.

module tb_htif_tohost_uart;

    localparam int CLK_HZ   = 24000000;
    localparam int BAUD     = 115200;
    localparam int POLL_GAP = 64;
    localparam int DIV      = CLK_HZ / BAUD;   // 208
    localparam int POLL_PER = POLL_GAP + 2;    // gap + RD_REQ + RD_RESP with ready host

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_rw;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_data;
    logic        uart_txd, busy, halted;
    logic [14:0] exit_code;

    htif_tohost_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .POLL_GAP(POLL_GAP)) dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .uart_txd            (uart_txd),
        .busy                (busy),
        .halted              (halted),
        .exit_code           (exit_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- host model (owns the DUT inputs except reset) ----------------
    bit          ready_en = 1'b1;
    logic [63:0] tohost_new = 64'h0;
    int          tohost_seq = 0;
    logic [63:0] tohost = 64'h0;
    int          seen_seq = 0;
    bit          req_fire_q = 1'b0, resp_fire_q = 1'b0, pend_is_write = 1'b0;
    int          cyc = 0, rd_cnt = 0, wr_cnt = 0, rd_period = 0, last_rd_cyc = 0;
    int          txd_low_cnt = 0;
    logic [11:0] wr_addr = 12'h0;
    logic [63:0] wr_data = 64'h0;

    initial begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 64'h0;
    end

    // Inputs change on the falling edge; handshakes are decided from the values
    // that the next rising edge will see.
    always @(negedge clk) begin
        cyc++;
        if (uart_txd === 1'b0) txd_low_cnt++;
        if (tohost_seq != seen_seq) begin
            tohost   = tohost_new;
            seen_seq = tohost_seq;
        end
        if (reset) begin
            resp_valid  = 1'b0;
            resp_data   = 64'h0;
            req_fire_q  = 1'b0;
            resp_fire_q = 1'b0;
            req_ready   = ready_en;
        end else begin
            if (resp_fire_q) resp_valid = 1'b0;
            if (req_fire_q) begin
                resp_valid = 1'b1;
                resp_data  = pend_is_write ? 64'hFFFF_FFFF_FFFF_FFFF : tohost;
            end
            req_ready  = ready_en;
            req_fire_q = req_valid && req_ready;
            if (req_fire_q) begin
                if (req_rw) begin
                    wr_cnt++;
                    wr_addr       = req_addr;
                    wr_data       = req_data;
                    tohost        = req_data;
                    pend_is_write = 1'b1;
                end else begin
                    rd_cnt++;
                    rd_period     = cyc - last_rd_cyc;
                    last_rd_cyc   = cyc;
                    pend_is_write = 1'b0;
                end
            end
            resp_fire_q = resp_valid && resp_ready;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_req(input int limit, output int n);
        n = 0;
        while (req_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (req_valid !== 1'b1) n = -1;
    endtask

    task automatic wait_txd_low(input int limit, output logic ok);
        int n = 0;
        while (uart_txd !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (uart_txd === 1'b0);
    endtask

    // Captures ten mid-bit samples. It also samples the last start cycle and
    // the first bit0 cycle, which checks the start-bit length for bytes with bit0=1.
    task automatic rx_frame(input int limit, output logic [9:0] bits, output logic ok,
                            output logic s_last, output logic s_next, output logic busy_mid);
        bits = '1; s_last = 1'b1; s_next = 1'b0; busy_mid = 1'b0;
        wait_txd_low(limit, ok);
        if (ok) begin
            for (int i = 0; i < 10 * DIV; i++) begin
                if (i > 0) @(negedge clk);
                if (i % DIV == DIV / 2) bits[i / DIV] = uart_txd;
                if (i == DIV - 1) s_last = uart_txd;
                if (i == DIV) s_next = uart_txd;
                if (i == DIV / 2) busy_mid = busy;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    int          n, r, wr0, low0;
    logic        ok, s_last, s_next, busy_mid, stable;
    logic [9:0]  bits;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", req_valid, 0);
        check("rst_rw", req_rw, 0);
        check("rst_req_data", req_data, 0);
        check("rst_resp_ready", resp_ready, 0);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_addr", req_addr, 12'h780);

        @(negedge clk);
        #2 reset = 1'b0;
        wait_req(200, n);
        check("first_poll_delay", n, POLL_GAP);
        check("first_poll_rw", req_rw, 0);

        // tohost stays zero: periodic reads, no writes, line idle
        wr0 = wr_cnt; low0 = txd_low_cnt; r = rd_cnt;
        repeat (5 * POLL_PER + 10) @(negedge clk);
        check("idle_period", rd_period, POLL_PER);
        check("idle_reads_ge4", (rd_cnt - r) >= 4, 1);
        check("idle_writes", wr_cnt - wr0, 0);
        check("idle_txd_low", txd_low_cnt - low0, 0);

        // 'A' with junk in the upper bytes
        wr0 = wr_cnt;
        tohost_new = 64'h0000_0101_0000_0041; tohost_seq++;
        rx_frame(400, bits, ok, s_last, s_next, busy_mid);
        check("A_frame_seen", ok, 1);
        check("A_frame_bits", bits, 10'h282);
        check("A_start_last", s_last, 0);
        check("A_start_len", s_next, 1);
        check("A_busy_in_tx", busy_mid, 1);
        check("A_writes", wr_cnt - wr0, 1);
        check("A_wr_addr", wr_addr, 12'h780);
        check("A_wr_data", wr_data, 64'h0);
        @(negedge clk);
        check("A_idle_after", uart_txd, 1);
        low0 = txd_low_cnt; r = rd_cnt;
        repeat (200) @(negedge clk);
        check("A_no_second_frame", txd_low_cnt - low0, 0);
        check("A_polls_resume", (rd_cnt - r) >= 2, 1);
        check("A_single_write", wr_cnt - wr0, 1);

        // stall the read request for 50 cycles
        r = rd_cnt; n = 0;
        while (rd_cnt == r && n < 200) begin @(negedge clk); n++; end
        ready_en = 1'b0;
        wait_req(200, n);
        check("stall_req_seen", n >= 0, 1);
        r = rd_cnt; stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (req_valid !== 1'b1 || req_rw !== 1'b0 || req_addr !== 12'h780) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        check("stall_no_accept", rd_cnt - r, 0);
        ready_en = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_one_accept", rd_cnt - r, 1);

        // reset during data bit 3 of 'A'
        tohost_new = 64'h41; tohost_seq++;
        wait_txd_low(400, ok);
        check("rstmid_frame_seen", ok, 1);
        repeat (4 * DIV + DIV / 2) @(negedge clk);
        check("rstmid_at_bit3", uart_txd, 0);
        #2 reset = 1'b1;
        #1;
        check("rstmid_txd", uart_txd, 1);
        check("rstmid_req_valid", req_valid, 0);
        check("rstmid_busy", busy, 0);
        repeat (3) @(negedge clk);
        low0 = txd_low_cnt; wr0 = wr_cnt;
        #2 reset = 1'b0;
        wait_req(200, n);
        check("rstmid_restart_delay", n, POLL_GAP);
        repeat (300) @(negedge clk);
        check("rstmid_no_resume", txd_low_cnt - low0, 0);
        check("rstmid_no_write", wr_cnt - wr0, 0);

        // odd value 7: exit with HALT enabled, plain character otherwise
        wr0 = wr_cnt; low0 = txd_low_cnt;
        tohost_new = 64'h7; tohost_seq++;
`ifdef TOHOST_HALT_EN
        n = 0;
        while (halted !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check("halt_entered", halted, 1);
        check("halt_exit_code", exit_code, 15'd3);
        check("halt_cleared", wr_cnt - wr0, 1);
        check("halt_wr_data", wr_data, 64'h0);
        r = rd_cnt;
        repeat (10000) @(negedge clk);
        check("halt_no_requests", rd_cnt - r, 0);
        check("halt_no_uart", txd_low_cnt - low0, 0);
        check("halt_sticky", halted, 1);
        check("halt_busy", busy, 1);
`else
        rx_frame(400, bits, ok, s_last, s_next, busy_mid);
        check("x07_frame_seen", ok, 1);
        check("x07_frame_bits", bits, 10'h20E);
        check("x07_start_len", s_next, 1);
        check("x07_cleared", wr_cnt - wr0, 1);
        check("x07_halted", halted, 0);
        check("x07_exit_code", exit_code, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
